control_unit: RTL and testbench
===============================

# control_unit

Multicycle control FSM for the CPU datapath. Decodes the opcode/funct fields from the instruction register and the ALU flags, and drives every write enable, mux select and ALU operation in the datapath (PC, memory, IR, register bank, A/B/ALUOut registers). It sits directly upstream of the datapath, one instance per CPU. It halts permanently on an illegal instruction or an arithmetic overflow.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces state RESET immediately.
- opcode  in  6  instruction bits 31:26.
- funct  in  6  instruction bits 5:0.
- zero  in  1  ALU Zero flag.
- overflow  in  1  ALU Overflow flag.
- pc_write  out  1  load PC.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  load IR.
- reg_write  out  1  register bank write.
- a_write, b_write, aluout_write  out  1 each  load A, B, ALUOut.
- mem_to_reg  out  1  1 = write-back data from memory, 0 = ALUOut.
- reg_dest  out  1  1 = rd (bits 15:11), 0 = rt.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], imm26, 00}.
- alu_control  out  3  001 add, 010 sub, 011 and; 000 otherwise.
- halted  out  1  1 while in HALT.
- state  out  4  current state encoding, for debug.

## Operation
- Supported: R-type (opcode 0x00) add 0x20, sub 0x22, and 0x24; addi 0x08; lw 0x23; sw 0x2B; beq 0x04; bne 0x05; j 0x02.
- Any other opcode, or an R-type funct outside this list, is illegal.
- Outputs are decoded from the state alone (Moore). The only exception is pc_write in BRANCH, which also depends on zero.
- Any output not listed for a state is 0.
- State encodings: RESET 0, FETCH 1, FETCH_WAIT 2, DECODE 3, EXEC_R 4, EXEC_I 5, ADDR 6, MEM_READ 7, MEM_WAIT 8, MEM_WRITE 9, WB_R 10, WB_I 11, WB_MEM 12, BRANCH 13, JUMP 14, HALT 15.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_control=add, pc_source=00, pc_write=1. This issues the memory read at the old PC and loads PC+4. Next: FETCH_WAIT.
- FETCH_WAIT: ir_write=1. Next: DECODE.
- DECODE: a_write=1, b_write=1, alu_src_a=0, alu_src_b=11, alu_control=add, aluout_write=1, which precomputes the branch target. Next state by opcode:
  - R-type → EXEC_R
  - addi → EXEC_I
  - lw/sw → ADDR
  - beq/bne → BRANCH
  - j → JUMP
  - illegal → HALT
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_control from funct, aluout_write=1. Next: HALT if overflow and funct is add or sub; otherwise WB_R.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_control=add, aluout_write=1. Next: HALT if overflow; otherwise WB_I.
- ADDR: same ALU setup as EXEC_I; overflow is ignored. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: iord=1. Next: MEM_WAIT.
- MEM_WAIT: iord=1. Next: WB_MEM.
- MEM_WRITE: iord=1, mem_write=1. Next: FETCH.
- WB_R: reg_write=1, reg_dest=1, mem_to_reg=0. Next: FETCH.
- WB_I: reg_write=1, reg_dest=0, mem_to_reg=0. Next: FETCH.
- WB_MEM: reg_write=1, reg_dest=0, mem_to_reg=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=sub, pc_source=01.
  - pc_write = zero for beq.
  - pc_write = !zero for bne.
  - Next: FETCH.
- JUMP: pc_source=10, pc_write=1. Next: FETCH.
- HALT: halted=1, all enables 0. Stays in HALT until reset.

## Timing
- Reset assertion clears state to RESET asynchronously. While reset is low, all outputs read 0 and state reads 0.
- The first FETCH is two rising edges after reset deasserts (RESET → FETCH).
- Instruction latency, FETCH to next FETCH:
  - R-type, addi, sw: 5 cycles
  - lw: 7 cycles
  - beq, bne, j: 4 cycles
- Overflow is sampled only on the EXEC_R/EXEC_I clock edge. In that case no reg_write is ever issued for the instruction.
- Reset asserted mid-instruction aborts it. No further write enables are issued after the asynchronous clear.

## Test plan
- Reset then add (opcode 0x00, funct 0x20, overflow=0) → states 0,1,2,3,4,10,1; reg_write=1 and reg_dest=1 only in state 10.
- lw (0x23) → states 1,2,3,6,7,8,12,1; mem_to_reg=1 and reg_write=1 in state 12; iord=1 in states 7 and 8.
- beq with zero=1 → pc_write=1 in BRANCH with pc_source=01. Repeat with zero=0 → pc_write=0. bne gives the inverse result.
- addi with overflow=1 in EXEC_I → next state HALT, halted=1, reg_write never asserted. Holds for 20 cycles; reset low then high returns to FETCH.
- Illegal opcode 0x3F, and R-type funct 0x2A → DECODE/EXEC path goes to HALT; no pc_write after FETCH.
- Reset pulsed low during MEM_WAIT of an lw → outputs 0 immediately, no reg_write; after release the state sequence is 0 then 1.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multicycle control FSM for the CPU datapath.
// Moore-style decode of every datapath enable/select from the current state.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       a_write,
    output logic       b_write,
    output logic       aluout_write,
    output logic       mem_to_reg,
    output logic       reg_dest,
    output logic       iord,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_control,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC_R     = 4'd4,
        S_EXEC_I     = 4'd5,
        S_ADDR       = 4'd6,
        S_MEM_READ   = 4'd7,
        S_MEM_WAIT   = 4'd8,
        S_MEM_WRITE  = 4'd9,
        S_WB_R       = 4'd10,
        S_WB_I       = 4'd11,
        S_WB_MEM     = 4'd12,
        S_BRANCH     = 4'd13,
        S_JUMP       = 4'd14,
        S_HALT       = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_t cur;
    state_t nxt;
    logic   run;

    logic is_r;
    logic r_ok;
    logic fn_arith;
    logic is_addi;
    logic is_mem;
    logic is_br;
    logic is_j;
    logic [2:0] r_alu;

    assign is_r     = (opcode == OP_RTYPE);
    assign fn_arith = (funct == FN_ADD) || (funct == FN_SUB);
    assign r_ok     = is_r && (fn_arith || (funct == FN_AND));
    assign is_addi  = (opcode == OP_ADDI);
    assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_j     = (opcode == OP_J);
    assign state    = cur;

    // ALU operation selected by an R-type funct field
    always_comb begin
        r_alu = ALU_NONE;
        case (funct)
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            default: r_alu = ALU_NONE;
        endcase
    end

    // Reset release is registered so the FSM leaves RESET on the second edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run <= 1'b0;
        else        run <= 1'b1;
    end

    // State register, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= S_RESET;
        else        cur <= nxt;
    end

    // Next-state logic and state-decoded datapath controls
    always_comb begin
        nxt          = cur;
        pc_write     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        a_write      = 1'b0;
        b_write      = 1'b0;
        aluout_write = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dest     = 1'b0;
        iord         = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_B;
        pc_source    = PCSRC_ALU;
        alu_control  = ALU_NONE;
        halted       = 1'b0;

        case (cur)
            S_RESET: begin
                nxt = run ? S_FETCH : S_RESET;
            end
            S_FETCH: begin
                alu_src_b   = SRCB_4;
                alu_control = ALU_ADD;
                pc_write    = 1'b1;
                nxt         = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                ir_write = 1'b1;
                nxt      = S_DECODE;
            end
            S_DECODE: begin
                a_write      = 1'b1;
                b_write      = 1'b1;
                alu_src_b    = SRCB_IMM4;
                alu_control  = ALU_ADD;
                aluout_write = 1'b1;
                unique case (1'b1)
                    r_ok:    nxt = S_EXEC_R;
                    is_addi: nxt = S_EXEC_I;
                    is_mem:  nxt = S_ADDR;
                    is_br:   nxt = S_BRANCH;
                    is_j:    nxt = S_JUMP;
                    default: nxt = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a    = 1'b1;
                alu_control  = r_alu;
                aluout_write = 1'b1;
                nxt = (overflow && fn_arith) ? S_HALT : S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_control  = ALU_ADD;
                aluout_write = 1'b1;
                nxt = overflow ? S_HALT : S_WB_I;
            end
            S_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_control  = ALU_ADD;
                aluout_write = 1'b1;
                nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                iord = 1'b1;
                nxt  = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                iord = 1'b1;
                nxt  = S_WB_MEM;
            end
            S_MEM_WRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dest  = 1'b1;
                nxt       = S_FETCH;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_source   = PCSRC_ALUOUT;
                pc_write    = (opcode == OP_BEQ) ? zero : !zero;
                nxt         = S_FETCH;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
                nxt       = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                nxt    = S_HALT;
            end
            default: nxt = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for the multicycle control FSM.
// Expected per-cycle state/controls come from an instruction-level model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic       pc_write, mem_write, ir_write, reg_write;
    logic       a_write, b_write, aluout_write;
    logic       mem_to_reg, reg_dest, iord, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_control;
    logic       halted;
    logic [3:0] state;

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow),
        .pc_write(pc_write), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .a_write(a_write), .b_write(b_write),
        .aluout_write(aluout_write), .mem_to_reg(mem_to_reg),
        .reg_dest(reg_dest), .iord(iord), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_control(alu_control), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, memw, irw, regw, aw, bw, aow, m2r, rdst, iord, srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aluc;
        logic halted;
    } outs_t;

    typedef struct packed {
        logic [3:0] st;
        outs_t      o;
    } rec_t;

    rec_t  expq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    mon_on = 1'b0;
    outs_t got;
    rec_t  mon_r;

    assign got = {pc_write, mem_write, ir_write, reg_write, a_write,
                  b_write, aluout_write, mem_to_reg, reg_dest, iord,
                  alu_src_a, alu_src_b, pc_source, alu_control, halted};

    // Controls expected while in a given state
    function automatic rec_t model(int st, logic [5:0] op,
                                   logic [5:0] fn, logic z);
        rec_t r;
        r = '0;
        r.st = 4'(st);
        case (st)
            1: begin r.o.srcb = 2'd1; r.o.aluc = 3'd1; r.o.pcw = 1'b1; end
            2: r.o.irw = 1'b1;
            3: begin
                r.o.aw = 1'b1; r.o.bw = 1'b1; r.o.aow = 1'b1;
                r.o.srcb = 2'd3; r.o.aluc = 3'd1;
            end
            4: begin
                r.o.srca = 1'b1; r.o.aow = 1'b1;
                r.o.aluc = (fn == 6'h20) ? 3'd1 :
                           (fn == 6'h22) ? 3'd2 : 3'd3;
            end
            5, 6: begin
                r.o.srca = 1'b1; r.o.srcb = 2'd2;
                r.o.aluc = 3'd1; r.o.aow = 1'b1;
            end
            7, 8: r.o.iord = 1'b1;
            9: begin r.o.iord = 1'b1; r.o.memw = 1'b1; end
            10: begin r.o.regw = 1'b1; r.o.rdst = 1'b1; end
            11: r.o.regw = 1'b1;
            12: begin r.o.regw = 1'b1; r.o.m2r = 1'b1; end
            13: begin
                r.o.srca = 1'b1; r.o.aluc = 3'd2; r.o.pcsrc = 2'd1;
                r.o.pcw = (op == 6'h04) ? z : !z;
            end
            14: begin r.o.pcsrc = 2'd2; r.o.pcw = 1'b1; end
            15: r.o.halted = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] g, logic [31:0] e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, g, e);
        end
    endtask

    // Monitor: pops one expected record per cycle and compares
    always @(posedge clk) begin
        #2;
        if (mon_on) begin
            if (expq.size() == 0) begin
                chk("queue_underflow", 32'd0, 32'd1);
            end else begin
                mon_r = expq.pop_front();
                chk("state", 32'(state), 32'(mon_r.st));
                chk("controls", 32'(got), 32'(mon_r.o));
            end
        end
    end

    task automatic do_reset();
        rec_t z0;
        z0 = '0;
        @(negedge clk);
        mon_on = 1'b1;
        reset = 1'b0;
        #1;
        chk("async_clr_state", 32'(state), 32'd0);
        chk("async_clr_ctrl", 32'(got), 32'd0);
        expq.push_back(z0);
        @(negedge clk);
        expq.push_back(z0);
        @(negedge clk);
        reset = 1'b1;
        expq.push_back(z0);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ov,
                             input int stop_at);
        int seq[$];
        seq = '{1, 2, 3};
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            seq.push_back(4);
            seq.push_back((ov && fn != 6'h24) ? 15 : 10);
        end else if (op == 6'h08) begin
            seq.push_back(5);
            seq.push_back(ov ? 15 : 11);
        end else if (op == 6'h23) begin
            seq.push_back(6); seq.push_back(7);
            seq.push_back(8); seq.push_back(12);
        end else if (op == 6'h2B) begin
            seq.push_back(6); seq.push_back(9);
        end else if (op == 6'h04 || op == 6'h05) begin
            seq.push_back(13);
        end else if (op == 6'h02) begin
            seq.push_back(14);
        end else begin
            seq.push_back(15);
        end
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            opcode = op;
            funct = fn;
            zero = z;
            if (i > 0 && (seq[i-1] == 4 || seq[i-1] == 5))
                overflow = ov;
            else
                overflow = 1'($urandom);
            expq.push_back(model(seq[i], op, fn, z));
            if (seq[i] == stop_at) begin
                do_reset();
                return;
            end
        end
        if (seq[seq.size()-1] == 15) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                opcode = 6'($urandom);
                funct = 6'($urandom);
                zero = 1'($urandom);
                overflow = 1'($urandom);
                expq.push_back(model(15, opcode, funct, zero));
            end
            do_reset();
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        logic z, ov;
        int pick;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_ctrl", 32'(got), 32'd0);
        do_reset();
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1);
        run_instr(6'h23, 6'h11, 1'b0, 1'b1, -1);
        run_instr(6'h04, 6'h00, 1'b1, 1'b0, -1);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h05, 6'h00, 1'b1, 1'b0, -1);
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, 1'b1, -1);
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h00, 6'h24, 1'b0, 1'b1, -1);
        run_instr(6'h08, 6'h00, 1'b0, 1'b1, -1);
        run_instr(6'h3F, 6'h20, 1'b0, 1'b0, -1);
        run_instr(6'h00, 6'h2A, 1'b0, 1'b0, -1);
        run_instr(6'h00, 6'h22, 1'b0, 1'b1, -1);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 8);
        run_instr(6'h08, 6'h00, 1'b0, 1'b0, -1);
        for (int n = 0; n < 120; n++) begin
            pick = $urandom_range(0, 9);
            fn = 6'($urandom);
            z = 1'($urandom);
            ov = ($urandom_range(0, 3) == 0);
            case (pick)
                0: begin op = 6'h00; fn = 6'h20; end
                1: begin op = 6'h00; fn = 6'h22; end
                2: begin op = 6'h00; fn = 6'h24; end
                3: op = 6'h08;
                4: op = 6'h23;
                5: op = 6'h2B;
                6: op = 6'h04;
                7: op = 6'h05;
                8: op = 6'h02;
                default: op = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
            endcase
            run_instr(op, fn, z, ov, (pick == 4 && $urandom_range(0, 7) == 0) ? 8 : -1);
        end
        @(posedge clk);
        #3;
        mon_on = 1'b0;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
